// File: rtl/uart_frame_parser.sv
// Frame decoder for the PC link: parses SYNC|CMD|LEN|PAYLOAD|CSUM frames from uart_rx,
// streams payload bytes out, and queues a one-byte ACK/NACK for uart_tx.
module uart_frame_parser #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter logic [7:0] ACK_BYTE    = 8'hAB,
  parameter logic [7:0] NACK_BYTE   = 8'hEE,
  parameter int         MAX_LEN     = 64,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic [7:0] cmd,
  output logic [7:0] pl_data,
  output logic [7:0] pl_index,
  output logic       pl_valid,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_CSUM} state_t;

  state_t        state_q, state_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    pl_data_q, pl_data_d;
  logic [7:0]    pl_index_q, pl_index_d;
  logic          pl_valid_q, pl_valid_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic          pend_q, pend_d;
  logic [7:0]    resp_q, resp_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic [1:0]    hold_q, hold_d;

  logic          queue_ev;
  logic [7:0]    queue_byte;
  logic          tmo_expire;

  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign tmo_expire = (state_q != S_IDLE) && !rx_ready && (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d    = state_q;
    csum_d     = csum_q;
    len_d      = len_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    cmd_d      = cmd_q;
    pl_data_d  = pl_data_q;
    pl_index_d = pl_index_q;
    pl_valid_d = 1'b0;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    code_d     = code_q;
    queue_ev   = 1'b0;
    queue_byte = NACK_BYTE;

    if (rx_ready) begin
      tmo_d = '0;
      case (state_q)
        S_IDLE: if (rx_data == SYNC_BYTE) state_d = S_CMD;
        S_CMD: begin
          cmd_d   = rx_data;
          csum_d  = rx_data;
          state_d = S_LEN;
        end
        S_LEN: begin
          csum_d = csum_q ^ rx_data;
          len_d  = rx_data;
          if (rx_data > 8'(MAX_LEN)) begin
            err_d    = 1'b1;
            code_d   = 2'b10;
            queue_ev = 1'b1;
            state_d  = S_IDLE;
          end else if (rx_data == 8'd0) begin
            state_d = S_CSUM;
          end else begin
            idx_d   = 8'd0;
            state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          pl_data_d  = rx_data;
          pl_index_d = idx_q;
          pl_valid_d = 1'b1;
          csum_d     = csum_q ^ rx_data;
          idx_d      = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) state_d = S_CSUM;
        end
        S_CSUM: begin
          queue_ev = 1'b1;
          if (rx_data == csum_q) begin
            ok_d       = 1'b1;
            queue_byte = ACK_BYTE;
          end else begin
            err_d  = 1'b1;
            code_d = 2'b01;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (tmo_expire) begin
        err_d    = 1'b1;
        code_d   = 2'b11;
        queue_ev = 1'b1;
        tmo_d    = '0;
        state_d  = S_IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  // Response path: one pending slot, latest response wins, 2-cycle holdoff after a start.
  always_comb begin
    pend_d     = pend_q;
    resp_d     = resp_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    hold_d     = (hold_q == 2'd0) ? 2'd0 : hold_q - 2'd1;
    if (pend_q && !tx_busy && (hold_q == 2'd0)) begin
      tx_start_d = 1'b1;
      tx_data_d  = resp_q;
      pend_d     = 1'b0;
      hold_d     = 2'd2;
    end
    if (queue_ev) begin
      pend_d = 1'b1;
      resp_d = queue_byte;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      csum_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
      cmd_q      <= '0;
      pl_data_q  <= '0;
      pl_index_q <= '0;
      pl_valid_q <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= '0;
      pend_q     <= 1'b0;
      resp_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      csum_q     <= csum_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      cmd_q      <= cmd_d;
      pl_data_q  <= pl_data_d;
      pl_index_q <= pl_index_d;
      pl_valid_q <= pl_valid_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      code_q     <= code_d;
      pend_q     <= pend_d;
      resp_q     <= resp_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      hold_q     <= hold_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign cmd       = cmd_q;
  assign pl_data   = pl_data_q;
  assign pl_index  = pl_index_q;
  assign pl_valid  = pl_valid_q;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign err_code  = code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: directed byte streams push expected payload,
// frame-status and response entries; a negedge monitor pops and compares on each strobe.
module tb_uart_frame_parser;

  localparam int T = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [7:0] cmd;
  logic [7:0] pl_data;
  logic [7:0] pl_index;
  logic       pl_valid;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  uart_frame_parser #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_start(tx_start), .cmd(cmd), .pl_data(pl_data),
    .pl_index(pl_index), .pl_valid(pl_valid), .frame_ok(frame_ok),
    .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic [7:0] i; } pl_t;
  typedef struct packed { logic ok; logic [1:0] code; logic [7:0] cmd; } fr_t;

  pl_t        pl_q[$];
  fr_t        fr_q[$];
  logic [7:0] tx_q[$];
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic spurious(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: strobe seen with nothing expected", name);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_list(input logic [7:0] v[$], input int gap);
    foreach (v[i]) send(v[i], gap);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_cmd"}, cmd, 0);
    chk({tag, "_pl_data"}, pl_data, 0);
    chk({tag, "_pl_index"}, pl_index, 0);
    chk({tag, "_pl_valid"}, pl_valid, 0);
    chk({tag, "_frame_ok"}, frame_ok, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_err_code"}, err_code, 0);
  endtask

  // Monitor
  initial begin
    pl_t p;
    fr_t f;
    logic [7:0] t;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (pl_valid) begin
          if (pl_q.size() == 0) spurious("pl_valid");
          else begin
            p = pl_q.pop_front();
            chk("pl_data", pl_data, p.d);
            chk("pl_index", pl_index, p.i);
          end
        end
        if (frame_ok || frame_err) begin
          if (fr_q.size() == 0) spurious("frame_status");
          else begin
            f = fr_q.pop_front();
            chk("frame_ok", frame_ok, f.ok);
            chk("frame_err", frame_err, !f.ok);
            if (!f.ok) chk("err_code", err_code, f.code);
            chk("cmd", cmd, f.cmd);
          end
        end
        if (tx_start) begin
          if (tx_q.size() == 0) spurious("tx_start");
          else begin
            t = tx_q.pop_front();
            chk("tx_data", tx_data, t);
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    logic [7:0] v[$];
    int cnt;
    bit seen;
    reset = 1'b1; rx_ready = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    reset_check("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // good two-byte frame
    pl_q.push_back('{8'h10, 8'd0}); pl_q.push_back('{8'h20, 8'd1});
    fr_q.push_back('{1'b1, 2'b00, 8'h01}); tx_q.push_back(8'hAB);
    v = '{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
    send_list(v, 2);
    repeat (10) @(negedge clk);

    // bad checksum
    pl_q.push_back('{8'h10, 8'd0}); pl_q.push_back('{8'h20, 8'd1});
    fr_q.push_back('{1'b0, 2'b01, 8'h01}); tx_q.push_back(8'hEE);
    v = '{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34};
    send_list(v, 2);
    repeat (10) @(negedge clk);

    // LEN above MAX_LEN, trailing byte ignored
    fr_q.push_back('{1'b0, 2'b10, 8'h07}); tx_q.push_back(8'hEE);
    v = '{8'hA5, 8'h07, 8'h41, 8'h00};
    send_list(v, 2);
    repeat (10) @(negedge clk);

    // zero-length frame
    fr_q.push_back('{1'b1, 2'b00, 8'h05}); tx_q.push_back(8'hAB);
    v = '{8'hA5, 8'h05, 8'h00, 8'h05};
    send_list(v, 2);
    repeat (10) @(negedge clk);

    // timeout after CMD, exact latency
    fr_q.push_back('{1'b0, 2'b11, 8'h03}); tx_q.push_back(8'hEE);
    send(8'hA5, 2);
    send(8'h03, 0);
    seen = 1'b0;
    for (cnt = 1; cnt <= T + 5; cnt++) begin
      @(negedge clk);
      if (frame_err) begin seen = 1'b1; break; end
    end
    chk("timeout_latency", seen ? cnt : 0, T);
    repeat (10) @(negedge clk);

    // longest legal inter-byte gap, SYNC value inside payload
    pl_q.push_back('{8'hA5, 8'd0});
    fr_q.push_back('{1'b1, 2'b00, 8'h02}); tx_q.push_back(8'hAB);
    v = '{8'hA5, 8'h02, 8'h01, 8'hA5, 8'hA6};
    send_list(v, T - 2);
    repeat (10) @(negedge clk);

    // LEN == MAX_LEN, back-to-back bytes; XOR of 0..63 is 0 so csum = 09^40 = 49
    for (int i = 0; i < 64; i++) pl_q.push_back('{8'(i), 8'(i)});
    fr_q.push_back('{1'b1, 2'b00, 8'h09}); tx_q.push_back(8'hAB);
    send(8'hA5, 0); send(8'h09, 0); send(8'h40, 0);
    for (int i = 0; i < 64; i++) send(8'(i), 0);
    send(8'h49, 0);
    repeat (10) @(negedge clk);

    // noise, then two frames ending while tx_busy: only the later response goes out
    v = '{8'h00, 8'hFF, 8'h5A};
    send_list(v, 2);
    tx_busy = 1'b1;
    pl_q.push_back('{8'h5A, 8'd0});
    fr_q.push_back('{1'b1, 2'b00, 8'h10});
    v = '{8'hA5, 8'h10, 8'h01, 8'h5A, 8'h4B};
    send_list(v, 2);
    fr_q.push_back('{1'b0, 2'b01, 8'h22}); tx_q.push_back(8'hEE);
    v = '{8'hA5, 8'h22, 8'h00, 8'h00};
    send_list(v, 2);
    repeat (10) @(negedge clk);
    chk("tx_held_while_busy", tx_q.size(), 1);
    tx_busy = 1'b0;
    repeat (10) @(negedge clk);

    // reset mid-frame, then a clean frame
    pl_q.push_back('{8'h10, 8'd0});
    v = '{8'hA5, 8'h01, 8'h04, 8'h10};
    send_list(v, 1);
    reset = 1'b1;
    @(negedge clk);
    reset_check("midreset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("midreset_no_strobe", {7'd0, pl_valid, 6'd0, frame_ok, frame_err}, 0);
    pl_q.push_back('{8'h77, 8'd0});
    fr_q.push_back('{1'b1, 2'b00, 8'h03}); tx_q.push_back(8'hAB);
    v = '{8'hA5, 8'h03, 8'h01, 8'h77, 8'h75};
    send_list(v, 2);
    repeat (20) @(negedge clk);

    chk("pl_left", pl_q.size(), 0);
    chk("frame_left", fr_q.size(), 0);
    chk("tx_left", tx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
